accum_carry_norm: RTL and testbench



---
 rtl/accum_carry_norm.sv | 131 +++++++++++++
 tb/tb_accum_carry_norm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_carry_norm.sv
// Carry-save column resolver: captures C/S columns, adds them, and folds column carries into 17-bit digits.
// Optional build macro ACCUM_NORM_FULL_CARRY_EN adds ITER passes that ripple digits to non-redundant form.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// ADD   | per-column C+S into 21-bit sums
// NORM  | fold each column's upper bits into the digit above
// ITER  | (full-carry build) ripple bit 16 of each digit up by one
// DONE  | digits presented, waiting for out_ready
module accum_carry_norm #(
   parameter int NCOL = 67,
   parameter int IW   = 20,
   parameter int DW   = 16,
   parameter int NOUT = 68
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NCOL*IW-1:0]       in_C,
   input  logic [NCOL*IW-1:0]       in_S,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NOUT*(DW+1)-1:0]   out_D,
   output logic [6:0]               out_passes
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ADD  = 3'd1;
   localparam logic [2:0] NORM = 3'd2;
   localparam logic [2:0] DONE = 3'd3;
`ifdef ACCUM_NORM_FULL_CARRY_EN
   localparam logic [2:0] ITER = 3'd4;
   localparam logic [6:0] PASS_MAX = 7'd68;
`endif

   logic [2:0]    state;
   logic [IW-1:0] c_q   [NCOL];
   logic [IW-1:0] s_q   [NCOL];
   logic [IW:0]   sum_q [NCOL];
   logic [DW:0]   d_q   [NOUT];
   logic [DW:0]   d_norm[NOUT];
   logic [6:0]    passes_q;

   // Upper bits of a 21-bit column sum are at most 0x1F, so each digit fits in 17 bits.
   always_comb begin
      for (int m = 0; m < NOUT; m++) d_norm[m] = '0;
      d_norm[0] = {1'b0, sum_q[0][DW-1:0]};
      for (int m = 1; m < NCOL; m++)
         d_norm[m] = {1'b0, sum_q[m][DW-1:0]} + (DW+1)'(sum_q[m-1][IW:DW]);
      d_norm[NOUT-1] = (DW+1)'(sum_q[NCOL-1][IW:DW]);
   end

`ifdef ACCUM_NORM_FULL_CARRY_EN
   logic [DW:0] d_iter[NOUT];
   logic        carry_norm;
   logic        carry_iter;
   logic [6:0]  passes_inc;

   always_comb begin
      for (int m = 0; m < NOUT; m++) d_iter[m] = '0;
      d_iter[0] = {1'b0, d_q[0][DW-1:0]};
      for (int m = 1; m < NCOL; m++)
         d_iter[m] = {1'b0, d_q[m][DW-1:0]} + (DW+1)'(d_q[m-1][DW]);
      d_iter[NOUT-1] = d_q[NOUT-1] + (DW+1)'(d_q[NOUT-2][DW]);
      carry_norm = 1'b0;
      carry_iter = 1'b0;
      for (int m = 0; m < NCOL; m++) begin
         carry_norm = carry_norm | d_norm[m][DW];
         carry_iter = carry_iter | d_iter[m][DW];
      end
      passes_inc = (passes_q >= PASS_MAX) ? PASS_MAX : passes_q + 7'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         passes_q <= '0;
         for (int m = 0; m < NCOL; m++) begin
            c_q[m]   <= '0;
            s_q[m]   <= '0;
            sum_q[m] <= '0;
         end
         for (int m = 0; m < NOUT; m++) d_q[m] <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               for (int m = 0; m < NCOL; m++) begin
                  c_q[m] <= in_C[m*IW +: IW];
                  s_q[m] <= in_S[m*IW +: IW];
               end
               state <= ADD;
            end
            ADD: begin
               for (int m = 0; m < NCOL; m++)
                  sum_q[m] <= {1'b0, c_q[m]} + {1'b0, s_q[m]};
               state <= NORM;
            end
            NORM: begin
               for (int m = 0; m < NOUT; m++) d_q[m] <= d_norm[m];
               passes_q <= 7'd1;
`ifdef ACCUM_NORM_FULL_CARRY_EN
               state <= carry_norm ? ITER : DONE;
`else
               state <= DONE;
`endif
            end
`ifdef ACCUM_NORM_FULL_CARRY_EN
            ITER: begin
               for (int m = 0; m < NOUT; m++) d_q[m] <= d_iter[m];
               passes_q <= passes_inc;
               if (!carry_iter || passes_inc == PASS_MAX) state <= DONE;
            end
`endif
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign out_passes = passes_q;

   always_comb begin
      out_D = '0;
      for (int m = 0; m < NOUT; m++) out_D[m*(DW+1) +: DW+1] = d_q[m];
   end

endmodule

// File: tb/tb_accum_carry_norm.sv
// Scoreboard bench for accum_carry_norm: directed vectors push expectations, a monitor checks every output.
// Runs in both builds; ACCUM_NORM_FULL_CARRY_EN selects the full-carry expectations.
module tb_accum_carry_norm;
   localparam int NCOL = 67;
   localparam int IW   = 20;
   localparam int DW   = 16;
   localparam int NOUT = 68;
   localparam int OW   = NOUT*(DW+1);
   localparam int WW   = 1100;
   localparam int CW   = 1200;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [NCOL*IW-1:0] in_C;
   logic [NCOL*IW-1:0] in_S;
   logic              out_valid;
   logic              out_ready;
   logic [OW-1:0]     out_D;
   logic [6:0]        out_passes;

   accum_carry_norm #(.NCOL(NCOL), .IW(IW), .DW(DW), .NOUT(NOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_C(in_C), .in_S(in_S), .out_valid(out_valid), .out_ready(out_ready),
      .out_D(out_D), .out_passes(out_passes)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] wsum;
      logic          chk_d;
      logic [OW-1:0] d;
      logic          chk_p;
      logic [6:0]    p;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic rnd_ready = 1'b0;

   task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   function automatic logic [WW-1:0] wsum_in(input logic [NCOL*IW-1:0] c, input logic [NCOL*IW-1:0] s);
      logic [WW-1:0] acc, t;
      acc = '0;
      for (int m = 0; m < NCOL; m++) begin
         t = WW'(c[m*IW +: IW]) + WW'(s[m*IW +: IW]);
         acc = acc + (t << (16*m));
      end
      return acc;
   endfunction

   function automatic logic [WW-1:0] wsum_out(input logic [OW-1:0] d);
      logic [WW-1:0] acc;
      acc = '0;
      for (int m = 0; m < NOUT; m++) acc = acc + (WW'(d[m*17 +: 17]) << (16*m));
      return acc;
   endfunction

   function automatic logic [OW-1:0] dset(input logic [OW-1:0] v, input int m, input logic [16:0] x);
      v[m*17 +: 17] = x;
      return v;
   endfunction

   // monitor: every accepted output is checked against the head of the queue
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp_t e;
            logic nr;
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got out_valid=1 want no output pending");
            end else begin
               e = q.pop_front();
               chk("digit_sum", wsum_out(out_D), e.wsum);
               if (e.chk_d) chk("digits", out_D, e.d);
               if (e.chk_p) chk("passes", out_passes, e.p);
`ifdef ACCUM_NORM_FULL_CARRY_EN
               nr = 1'b0;
               for (int m = 0; m < NCOL; m++) nr = nr | out_D[m*17 + 16];
               chk("nonredundant", nr, 1'b0);
`endif
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout: got still running want finished");
      $fatal(1, "timeout");
   end

   task automatic send(input logic [NCOL*IW-1:0] c, input logic [NCOL*IW-1:0] s,
                       input logic chk_d, input logic [OW-1:0] d,
                       input logic chk_p, input logic [6:0] p, input int lat);
      exp_t e;
      int   k;
      e.wsum = wsum_in(c, s);
      e.chk_d = chk_d; e.d = d; e.chk_p = chk_p; e.p = p;
      in_C = c; in_S = s; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 500) begin
         @(posedge clk); #1; k++;
      end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL in_ready_timeout: got 0 want 1");
         in_valid = 1'b0;
         return;
      end
      q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (lat > 0) begin
         k = 0;
         while (!out_valid && k < 200) begin
            @(posedge clk); #1; k++;
         end
         chk("latency", k + 1, lat);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 2000) begin
         @(posedge clk); #1; k++;
      end
      if (q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
         q.delete();
      end
   endtask

   logic [NCOL*IW-1:0] c_v, s_v, z_v;
   logic [OW-1:0]      d_v, d_t2;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_C = '0; in_S = '0;
      z_v = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_D", out_D, '0);
      chk("reset_passes", out_passes, 7'd0);

      // reset one cycle after capture discards the operand
      in_C = '1; in_S = '1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("t1_out_valid", out_valid, 1'b0);
      chk("t1_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("t1_no_output", out_valid, 1'b0);
      end

      // single carry out of column 0
      c_v = '0; s_v = '0;
      c_v[19:0] = 20'hFFFFF; s_v[19:0] = 20'h00001;
      d_t2 = dset('0, 1, 17'h00010);
      send(c_v, s_v, 1'b1, d_t2, 1'b1, 7'd1, 3);
      drain();

      send(z_v, z_v, 1'b1, '0, 1'b1, 7'd1, 3);
      drain();

      // all-ones columns
      c_v = '1; s_v = '1;
      d_v = dset('0, 0, 17'h0FFFE);
      for (int m = 1; m < NCOL; m++) d_v = dset(d_v, m, 17'h1001D);
      d_v = dset(d_v, 67, 17'h0001F);
`ifdef ACCUM_NORM_FULL_CARRY_EN
      send(c_v, s_v, 1'b0, d_v, 1'b0, 7'd1, 0);
`else
      send(c_v, s_v, 1'b1, d_v, 1'b1, 7'd1, 3);
`endif
      drain();

      // long ripple: 0x10000 in column 0 over 0xFFFF columns
      c_v = '0; s_v = '0;
      for (int m = 0; m < NCOL; m++) c_v[m*IW +: IW] = 20'h0FFFF;
      s_v[19:0] = 20'h00001;
`ifdef ACCUM_NORM_FULL_CARRY_EN
      d_v = dset('0, 67, 17'h00001);
      send(c_v, s_v, 1'b1, d_v, 1'b1, 7'd67, 69);
`else
      d_v = dset('0, 1, 17'h10000);
      for (int m = 2; m < NCOL; m++) d_v = dset(d_v, m, 17'h0FFFF);
      send(c_v, s_v, 1'b1, d_v, 1'b1, 7'd1, 3);
`endif
      drain();

      // stalled output stays stable and ignores new operands
      out_ready = 1'b0;
      c_v = '0; s_v = '0;
      c_v[19:0] = 20'hFFFFF; s_v[19:0] = 20'h00001;
      send(c_v, s_v, 1'b1, d_t2, 1'b1, 7'd1, 3);
      in_C = '1; in_S = '1;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         chk("t5_hold_valid", out_valid, 1'b1);
         chk("t5_hold_digits", out_D, d_t2);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t5_in_ready_after_xfer", in_ready, 1'b1);
      repeat (4) begin
         @(posedge clk); #1;
         chk("t5_no_capture", out_valid, 1'b0);
      end
      drain();

      // random operands with random output stalls
      rnd_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         for (int m = 0; m < NCOL; m++) begin
            c_v[m*IW +: IW] = (n % 7 == 3) ? 20'hFFFFF : 20'($urandom);
            s_v[m*IW +: IW] = 20'($urandom);
         end
`ifdef ACCUM_NORM_FULL_CARRY_EN
         send(c_v, s_v, 1'b0, '0, 1'b0, 7'd1, 0);
`else
         send(c_v, s_v, 1'b0, '0, 1'b1, 7'd1, 0);
`endif
      end
      drain();
      rnd_ready = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
